membus_arb2: RTL and testbench
==============================

MEMBUS_ARB2 -- requirements
Module: membus_arb2

Interface
REQ-001 SHALL have parameter TIMEOUT, default 100, meaning max clk cycles spent in ADDR or DATA before the cycle is aborted as non-existent memory (range 2..1023).
REQ-002 SHALL have port clk  in  1  the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports a_rq_cyc / b_rq_cyc  in  1  requester A/B wants a memory cycle.
REQ-005 SHALL have ports a_rd_rq, a_wr_rq / b_rd_rq, b_wr_rq  in  1 each  requester read/write request; both set = read-modify-write.
REQ-006 SHALL have ports a_ma / b_ma  in  [18:35]  requester address; a_fmc_select / b_fmc_select  in  1  fast-memory select.
REQ-007 SHALL have ports a_mb_out / b_mb_out  in  [0:35]  write data; a_wr_rs / b_wr_rs  in  1  write restart pulse.
REQ-008 SHALL have ports a_addr_ack, a_rd_rs, a_nxm / b_addr_ack, b_rd_rs, b_nxm  out  1 each; a_mb_in / b_mb_in  out  [0:35]  read data.
REQ-009 SHALL have ports m_rq_cyc, m_rd_rq, m_wr_rq, m_fmc_select, m_wr_rs  out  1; m_ma  out  [18:35]; m_mb_out  out  [0:35]  to memory.
REQ-010 SHALL have ports m_addr_ack, m_rd_rs  in  1; m_mb_in  in  [0:35]  from memory.

Function
REQ-011 SHALL implement states IDLE, ADDR, DATA plus registered grant (A or B), last-served pointer, latched rd/wr flags, 10-bit timeout counter.
REQ-012 IDLE: if exactly one rq_cyc high, grant it; both high, grant the master not last served; none, stay IDLE; grant taken -> ADDR next cycle.
REQ-013 ADDR: m_rq_cyc, m_rd_rq, m_wr_rq, m_ma, m_fmc_select SHALL equal the granted master's inputs combinationally; m_rq_cyc forced 0 if granted rq_cyc drops.
REQ-014 ADDR: m_addr_ack SHALL be forwarded combinationally to granted master's addr_ack only; on it latch rd/wr flags, go DATA; if neither flag set go IDLE.
REQ-015 ADDR: granted rq_cyc low without m_addr_ack SHALL abort to IDLE next cycle, no nxm.
REQ-016 DATA: m_rd_rs forwarded to granted rd_rs; m_mb_in routed to granted mb_in; granted wr_rs and mb_out forwarded to m_wr_rs, m_mb_out.
REQ-017 DATA exit: write flag latched -> IDLE cycle after wr_rs seen; read only -> IDLE cycle after m_rd_rs; RMW exits only on wr_rs, ignoring rd_rs for exit.
REQ-018 Counter SHALL clear on entering ADDR and DATA, increment each cycle there; reaching TIMEOUT -> one-cycle nxm pulse to granted master, state IDLE, no other output.
REQ-019 Last-served pointer SHALL update to granted master on every exit from ADDR/DATA (completion, abort, timeout).
REQ-020 Non-granted master and all masters in IDLE SHALL see addr_ack, rd_rs, nxm = 0 and mb_in = 0 (wired-OR convention); m_* outputs SHALL be 0 in IDLE.
REQ-021 m_addr_ack/m_rd_rs arriving in IDLE or the wrong state SHALL be ignored and not forwarded.
REQ-022 Minimum one IDLE cycle SHALL separate consecutive granted cycles; a master holding rq_cyc while the other waits SHALL lose the next tie.

Reset
REQ-023 reset high at a clock edge SHALL force IDLE, clear grant, flags, counter, set last-served = B (A wins first tie), regardless of state.
REQ-024 All outputs SHALL be 0 the cycle after reset, including mid-cycle reset; memory sees m_rq_cyc drop.

Verification
REQ-025 A read only: a_rq_cyc,a_rd_rq, a_ma=0o20; mem acks cycle 3, rd_rs with m_mb_in=36'o123456111222 cycle 5 -> a_addr_ack, a_rd_rs same cycles, a_mb_in matches, b_* all 0, IDLE next.
REQ-026 Both request in same cycle after reset -> A granted first; B granted after A completes plus one IDLE cycle; next tie -> A (alternation).
REQ-027 B write: b_wr_rq, b_mb_out=36'o777740000100, ack then b_wr_rs -> m_wr_rs, m_mb_out match, IDLE next cycle.
REQ-028 A read, memory never acks, TIMEOUT=100 -> a_nxm one-cycle pulse 100 cycles after ADDR entry; m_rq_cyc 0 after; B then grantable.
REQ-029 RMW on A, reset asserted between rd_rs and wr_rs -> all outputs 0 next cycle, later a_wr_rs not forwarded, A wins next tie.
REQ-030 Spurious m_rd_rs in IDLE -> no rd_rs to A or B, state remains IDLE.

Source files
------------

// File: rtl/membus_arb2_if.sv
// Memory bus bundle shared by the two requesters and the memory port.
// A requester drives the request/address/write side (master); the arbiter
// answers on the acknowledge/read side (slave). On the memory port the
// arbiter is the master.
interface membus_arb2_if;
  logic         rq_cyc;
  logic         rd_rq;
  logic         wr_rq;
  logic         fmc_select;
  logic         wr_rs;
  logic [18:35] ma;
  logic [0:35]  mb_out;
  logic         addr_ack;
  logic         rd_rs;
  logic         nxm;
  logic [0:35]  mb_in;

  modport master (
    output rq_cyc, rd_rq, wr_rq, fmc_select, wr_rs, ma, mb_out,
    input  addr_ack, rd_rs, nxm, mb_in
  );

  modport slave (
    input  rq_cyc, rd_rq, wr_rq, fmc_select, wr_rs, ma, mb_out,
    output addr_ack, rd_rs, nxm, mb_in
  );
endinterface

// File: rtl/membus_arb2.sv
// Two-requester memory bus arbiter. One granted cycle at a time runs through
// ADDR (address handshake) and DATA (read restart / write restart), with
// round-robin tie breaking and a non-existent-memory timeout.
module membus_arb2 #(
  parameter int unsigned TIMEOUT = 100
) (
  input  logic          clk,
  input  logic          reset,
  membus_arb2_if.slave  a,
  membus_arb2_if.slave  b,
  membus_arb2_if.master m
);

  typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

  localparam logic [9:0] TimeoutLast = 10'(TIMEOUT - 1);

  state_e     state_q;
  logic       grant_q;  // 0 = A, 1 = B
  logic       last_q;   // last served master, same encoding
  logic       rd_q;
  logic       wr_q;
  logic       nxm_q;
  logic [9:0] cnt_q;

  logic         g_rq_cyc, g_rd_rq, g_wr_rq, g_fmc, g_wr_rs;
  logic [18:35] g_ma;
  logic [0:35]  g_mb_out;
  logic         timeout;
  logic         in_addr, in_data;

  // Memory never signals nxm itself; that pulse is generated here.
  logic unused_m_nxm;
  assign unused_m_nxm = m.nxm;

  assign timeout = (cnt_q == TimeoutLast);
  assign in_addr = (state_q == StAddr);
  assign in_data = (state_q == StData);

  // View of the currently granted requester.
  always_comb begin
    if (grant_q) begin
      g_rq_cyc = b.rq_cyc;
      g_rd_rq  = b.rd_rq;
      g_wr_rq  = b.wr_rq;
      g_fmc    = b.fmc_select;
      g_wr_rs  = b.wr_rs;
      g_ma     = b.ma;
      g_mb_out = b.mb_out;
    end else begin
      g_rq_cyc = a.rq_cyc;
      g_rd_rq  = a.rd_rq;
      g_wr_rq  = a.wr_rq;
      g_fmc    = a.fmc_select;
      g_wr_rs  = a.wr_rs;
      g_ma     = a.ma;
      g_mb_out = a.mb_out;
    end
  end

  // Arbitration FSM, timeout counter and registered nxm pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      nxm_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      nxm_q <= 1'b0;
      cnt_q <= cnt_q + 10'd1;
      unique case (state_q)
        StIdle: begin
          cnt_q <= '0;
          // A wins a tie only when B was served last.
          if (a.rq_cyc && (!b.rq_cyc || last_q)) begin
            grant_q <= 1'b0;
            state_q <= StAddr;
          end else if (b.rq_cyc) begin
            grant_q <= 1'b1;
            state_q <= StAddr;
          end
        end
        StAddr: begin
          if (m.addr_ack) begin
            rd_q  <= g_rd_rq;
            wr_q  <= g_wr_rq;
            cnt_q <= '0;
            if (g_rd_rq || g_wr_rq) begin
              state_q <= StData;
            end else begin
              state_q <= StIdle;
              last_q  <= grant_q;
            end
          end else if (!g_rq_cyc) begin
            state_q <= StIdle;
            last_q  <= grant_q;
          end else if (timeout) begin
            state_q <= StIdle;
            last_q  <= grant_q;
            nxm_q   <= 1'b1;
          end
        end
        StData: begin
          // Any write (including read-modify-write) finishes on wr_rs only.
          if (wr_q ? g_wr_rs : m.rd_rs) begin
            state_q <= StIdle;
            last_q  <= grant_q;
          end else if (timeout) begin
            state_q <= StIdle;
            last_q  <= grant_q;
            nxm_q   <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Combinational routing between the granted requester and memory.
  always_comb begin
    m.rq_cyc     = 1'b0;
    m.rd_rq      = 1'b0;
    m.wr_rq      = 1'b0;
    m.fmc_select = 1'b0;
    m.ma         = '0;
    m.wr_rs      = 1'b0;
    m.mb_out     = '0;
    if (in_addr) begin
      m.rq_cyc     = g_rq_cyc;
      m.rd_rq      = g_rd_rq;
      m.wr_rq      = g_wr_rq;
      m.fmc_select = g_fmc;
      m.ma         = g_ma;
    end
    if (in_data) begin
      m.wr_rs  = g_wr_rs;
      m.mb_out = g_mb_out;
    end

    a.addr_ack = in_addr && m.addr_ack && !grant_q;
    b.addr_ack = in_addr && m.addr_ack && grant_q;
    a.rd_rs    = in_data && m.rd_rs && !grant_q;
    b.rd_rs    = in_data && m.rd_rs && grant_q;
    a.nxm      = nxm_q && !grant_q;
    b.nxm      = nxm_q && grant_q;
    a.mb_in    = (in_data && !grant_q) ? m.mb_in : '0;
    b.mb_in    = (in_data && grant_q) ? m.mb_in : '0;
  end

endmodule

// File: tb/tb_membus_arb2.sv
// Directed bench for membus_arb2: a per-cycle vector table for the basic
// read, write, arbitration and abort flows, then hand-written sequences for
// timeout, reset in the middle of read-modify-write and spurious rd_rs.
module tb_membus_arb2;

  localparam logic [18:35] AMA = 18'o20;
  localparam logic [18:35] BMA = 18'o777;
  localparam logic [0:35]  AMB = 36'o111122223333;
  localparam logic [0:35]  BMB = 36'o777740000100;
  localparam logic [0:35]  RD  = 36'o123456111222;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  membus_arb2_if a_if ();
  membus_arb2_if b_if ();
  membus_arb2_if m_if ();

  membus_arb2 #(.TIMEOUT(100)) dut (
    .clk  (clk),
    .reset(reset),
    .a    (a_if.slave),
    .b    (b_if.slave),
    .m    (m_if.master)
  );

  int checks = 0;
  int failures = 0;

  // One row = one clock cycle: inputs applied, then expected outputs.
  // ai/bi = {rq_cyc, rd_rq, wr_rq, wr_rs}
  // fl    = {a_ack,a_rds,a_nxm, b_ack,b_rds,b_nxm, m_rq,m_rd,m_wr,m_fmc,m_wrs}
  typedef struct {
    string        name;
    bit           rst;
    bit [3:0]     ai;
    bit [3:0]     bi;
    bit           ack;
    bit           rds;
    logic [0:35]  mbin;
    bit [10:0]    fl;
    logic [0:35]  amb;
    logic [0:35]  bmb;
    logic [18:35] ma;
    logic [0:35]  mbo;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(string n, bit rst, bit [3:0] ai, bit [3:0] bi, bit ack, bit rds,
                              logic [0:35] mbin, bit [10:0] fl, logic [0:35] amb,
                              logic [0:35] bmb, logic [18:35] ma, logic [0:35] mbo);
    vec_t v;
    v.name = n; v.rst = rst; v.ai = ai; v.bi = bi; v.ack = ack; v.rds = rds; v.mbin = mbin;
    v.fl = fl; v.amb = amb; v.bmb = bmb; v.ma = ma; v.mbo = mbo;
    return v;
  endfunction

  function automatic logic [10:0] flags();
    return {a_if.addr_ack, a_if.rd_rs, a_if.nxm, b_if.addr_ack, b_if.rd_rs, b_if.nxm,
            m_if.rq_cyc, m_if.rd_rq, m_if.wr_rq, m_if.fmc_select, m_if.wr_rs};
  endfunction

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic drive(input bit rst, input bit [3:0] ai, input bit [3:0] bi, input bit ack,
                       input bit rds, input logic [0:35] mbin);
    reset         = rst;
    a_if.rq_cyc   = ai[3]; a_if.rd_rq = ai[2]; a_if.wr_rq = ai[1]; a_if.wr_rs = ai[0];
    b_if.rq_cyc   = bi[3]; b_if.rd_rq = bi[2]; b_if.wr_rq = bi[1]; b_if.wr_rs = bi[0];
    m_if.addr_ack = ack;
    m_if.rd_rs    = rds;
    m_if.mb_in    = mbin;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    drive(1'b1, 4'b0, 4'b0, 1'b0, 1'b0, '0);
    repeat (2) @(posedge clk);
  endtask

  int   found;
  logic prev_rq;

  initial begin
    a_if.ma = AMA; a_if.mb_out = AMB; a_if.fmc_select = 1'b0;
    b_if.ma = BMA; b_if.mb_out = BMB; b_if.fmc_select = 1'b1;
    m_if.nxm = 1'b0;
    drive(1'b1, 4'b0, 4'b0, 1'b0, 1'b0, '0);
    repeat (2) @(posedge clk);

    //              name          rst ai       bi       ack rds mbin  fl               amb bmb ma   mbo
    tbl.push_back(mk("reset",     1, 4'b0000, 4'b0000, 0, 0, '0, 11'b000_000_00000, '0, '0, '0,  '0));
    tbl.push_back(mk("a_rd_req",  0, 4'b1100, 4'b0000, 0, 0, '0, 11'b000_000_00000, '0, '0, '0,  '0));
    tbl.push_back(mk("a_rd_addr", 0, 4'b1100, 4'b0000, 0, 0, '0, 11'b000_000_11000, '0, '0, AMA, '0));
    tbl.push_back(mk("a_rd_ack",  0, 4'b1100, 4'b0000, 1, 0, '0, 11'b100_000_11000, '0, '0, AMA, '0));
    tbl.push_back(mk("a_rd_wait", 0, 4'b0000, 4'b0000, 0, 0, '0, 11'b000_000_00000, '0, '0, '0,  AMB));
    tbl.push_back(mk("a_rd_rs",   0, 4'b0000, 4'b0000, 0, 1, RD, 11'b010_000_00000, RD, '0, '0,  AMB));
    tbl.push_back(mk("a_rd_done", 0, 4'b0000, 4'b0000, 0, 0, RD, 11'b000_000_00000, '0, '0, '0,  '0));
    tbl.push_back(mk("reset2",    1, 4'b0000, 4'b0000, 0, 0, '0, 11'b000_000_00000, '0, '0, '0,  '0));
    tbl.push_back(mk("tie_req",   0, 4'b1100, 4'b1010, 0, 0, '0, 11'b000_000_00000, '0, '0, '0,  '0));
    tbl.push_back(mk("tie_a_addr",0, 4'b1100, 4'b1010, 0, 0, '0, 11'b000_000_11000, '0, '0, AMA, '0));
    tbl.push_back(mk("tie_a_ack", 0, 4'b1100, 4'b1010, 1, 0, '0, 11'b100_000_11000, '0, '0, AMA, '0));
    tbl.push_back(mk("tie_a_rs",  0, 4'b0000, 4'b1010, 0, 1, RD, 11'b010_000_00000, RD, '0, '0,  AMB));
    tbl.push_back(mk("gap_idle",  0, 4'b0000, 4'b1010, 0, 0, '0, 11'b000_000_00000, '0, '0, '0,  '0));
    tbl.push_back(mk("b_wr_addr", 0, 4'b1100, 4'b1010, 0, 0, '0, 11'b000_000_10110, '0, '0, BMA, '0));
    tbl.push_back(mk("b_wr_ack",  0, 4'b1100, 4'b1010, 1, 0, '0, 11'b000_100_10110, '0, '0, BMA, '0));
    tbl.push_back(mk("b_wr_wait", 0, 4'b1100, 4'b0000, 0, 0, '0, 11'b000_000_00000, '0, '0, '0,  BMB));
    tbl.push_back(mk("b_wr_rs",   0, 4'b1100, 4'b0001, 0, 0, '0, 11'b000_000_00001, '0, '0, '0,  BMB));
    tbl.push_back(mk("alt_idle",  0, 4'b1100, 4'b1010, 0, 0, '0, 11'b000_000_00000, '0, '0, '0,  '0));
    tbl.push_back(mk("alt_a_addr",0, 4'b1100, 4'b1010, 0, 0, '0, 11'b000_000_11000, '0, '0, AMA, '0));
    tbl.push_back(mk("a_abort",   0, 4'b0000, 4'b1010, 0, 0, '0, 11'b000_000_00000, '0, '0, AMA, '0));
    tbl.push_back(mk("abort_idle",0, 4'b0000, 4'b1010, 0, 0, '0, 11'b000_000_00000, '0, '0, '0,  '0));
    tbl.push_back(mk("b_addr2",   0, 4'b0000, 4'b1010, 0, 0, '0, 11'b000_000_10110, '0, '0, BMA, '0));
    tbl.push_back(mk("rst_mid",   1, 4'b0000, 4'b1010, 0, 0, '0, 11'b000_000_10110, '0, '0, BMA, '0));
    tbl.push_back(mk("post_rst",  0, 4'b0000, 4'b1010, 0, 0, '0, 11'b000_000_00000, '0, '0, '0,  '0));
    tbl.push_back(mk("b_drop",    0, 4'b0000, 4'b0000, 0, 0, '0, 11'b000_000_00010, '0, '0, BMA, '0));

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].rst, tbl[i].ai, tbl[i].bi, tbl[i].ack, tbl[i].rds, tbl[i].mbin);
      #1;
      chk({tbl[i].name, "/flags"}, flags(), tbl[i].fl);
      chk({tbl[i].name, "/a_mb_in"}, a_if.mb_in, tbl[i].amb);
      chk({tbl[i].name, "/b_mb_in"}, b_if.mb_in, tbl[i].bmb);
      chk({tbl[i].name, "/m_ma"}, m_if.ma, tbl[i].ma);
      chk({tbl[i].name, "/m_mb_out"}, m_if.mb_out, tbl[i].mbo);
    end

    // Memory never answers A: nxm pulse 100 cycles after ADDR entry.
    reset_dut();
    @(negedge clk);
    drive(1'b0, 4'b1100, 4'b0000, 1'b0, 1'b0, '0);
    found = -1;
    prev_rq = 1'b0;
    for (int i = 0; i < 300 && found < 0; i++) begin
      @(negedge clk);
      #1;
      if (a_if.nxm === 1'b1) found = i;
      else prev_rq = m_if.rq_cyc;
    end
    chk("to_cycle", found, 100);
    chk("to_mrq_before", prev_rq, 1'b1);
    chk("to_mrq_after", m_if.rq_cyc, 1'b0);
    chk("to_b_nxm", b_if.nxm, 1'b0);
    drive(1'b0, 4'b1100, 4'b1010, 1'b0, 1'b0, '0);
    @(negedge clk);
    #1;
    chk("to_pulse_end", a_if.nxm, 1'b0);
    chk("to_b_grant_ma", m_if.ma, BMA);
    chk("to_b_grant_rq", m_if.rq_cyc, 1'b1);

    // RMW on A, reset between rd_rs and wr_rs.
    reset_dut();
    @(negedge clk);
    drive(1'b0, 4'b1110, 4'b0000, 1'b0, 1'b0, '0);
    @(negedge clk);
    drive(1'b0, 4'b1110, 4'b0000, 1'b1, 1'b0, '0);
    #1;
    chk("rmw_ack", a_if.addr_ack, 1'b1);
    @(negedge clk);
    drive(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, RD);
    #1;
    chk("rmw_rd_rs", a_if.rd_rs, 1'b1);
    chk("rmw_mb_in", a_if.mb_in, RD);
    @(negedge clk);
    drive(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, '0);
    #1;
    chk("rmw_hold_data", m_if.mb_out, AMB);
    @(negedge clk);
    drive(1'b0, 4'b0001, 4'b0000, 1'b0, 1'b0, '0);
    #1;
    chk("rmw_rst_flags", flags(), 11'b0);
    chk("rmw_rst_mbout", m_if.mb_out, 36'b0);
    chk("rmw_rst_mbin", a_if.mb_in, 36'b0);
    @(negedge clk);
    drive(1'b0, 4'b1100, 4'b1010, 1'b0, 1'b0, '0);
    #1;
    chk("rmw_idle", flags(), 11'b0);
    @(negedge clk);
    #1;
    chk("rmw_tie_a_ma", m_if.ma, AMA);

    // Spurious handshakes while idle.
    reset_dut();
    @(negedge clk);
    drive(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b1, RD);
    #1;
    chk("spur_flags", flags(), 11'b0);
    chk("spur_a_mb", a_if.mb_in, 36'b0);
    chk("spur_b_mb", b_if.mb_in, 36'b0);
    @(negedge clk);
    drive(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, '0);
    #1;
    chk("spur_still_idle", flags(), 11'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
